// File: rtl/layer_2_maxpool.sv
// rtl/layer_2_maxpool.sv - 2x2 stride-2 max-pool over a raster binary32 pixel stream
// Optional frame_done output enabled by LAYER_2_MAXPOOL_FRAME_DONE_EN.
module layer_2_maxpool #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 208
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
    ,
    output logic                  frame_done
`endif
);

    localparam int CW   = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
    localparam int HALF = IMG_SIZE / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    generate
        if ((IMG_SIZE % 2) != 0 || IMG_SIZE < 2) begin : g_bad_size
            $error("layer_2_maxpool: IMG_SIZE must be even and >= 2");
        end
    endgenerate

    // Sign-magnitude float mapped onto an unsigned key that sorts like the value.
    function automatic logic [DATA_WIDTH-1:0] f_key(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? ~v : (v | {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        return (f_key(b) > f_key(a)) ? b : a;
    endfunction

    logic [DATA_WIDTH-1:0] r_linebuf [HALF];
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_frame_done;

    logic [HW-1:0]         w_idx;
    logic [DATA_WIDTH-1:0] w_pair;
    logic [DATA_WIDTH-1:0] w_pool;
    logic                  w_col_last;
    logic                  w_row_last;

    assign w_idx      = HW'(r_col >> 1);
    assign w_pair     = f_max(r_hold, data_in);
    assign w_pool     = f_max(r_linebuf[w_idx], w_pair);
    assign w_col_last = (r_col == LAST);
    assign w_row_last = (r_row == LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (valid_in) begin
                if (!r_col[0]) begin
                    r_hold <= data_in;
                end else if (r_row[0]) begin
                    r_data_out   <= w_pool;
                    r_valid_out  <= 1'b1;
                    r_frame_done <= w_col_last && w_row_last;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Top-row pair maxima wait here for the matching bottom-row pair.
    always_ff @(posedge Clk) begin
        if (!Rst && valid_in && r_col[0] && !r_row[0]) begin
            r_linebuf[w_idx] <= w_pair;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
    assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_layer_2_maxpool.sv
// tb/tb_layer_2_maxpool.sv - randomized self-checking bench for layer_2_maxpool
module tb_layer_2_maxpool;

    localparam int NA = 4;
    localparam int NB = 208;
    localparam int PB = NB * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b0, a_vin = 1'b0, a_vout;
    logic [31:0] a_din = '0, a_dout;
    logic        b_rst = 1'b0, b_vin = 1'b0, b_vout;
    logic [31:0] b_din = '0, b_dout;
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
    logic        a_fd, b_fd;
`endif

    layer_2_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(NA)) u_dut_a (
        .Clk(clk), .Rst(a_rst), .data_in(a_din), .valid_in(a_vin),
        .data_out(a_dout), .valid_out(a_vout)
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
        , .frame_done(a_fd)
`endif
    );

    layer_2_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(NB)) u_dut_b (
        .Clk(clk), .Rst(b_rst), .data_in(b_din), .valid_in(b_vin),
        .data_out(b_dout), .valid_out(b_vout)
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
        , .frame_done(b_fd)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] fa [16];
    logic [31:0] pa [4];
    logic [31:0] a_last;
    logic [31:0] fb [2*PB];

    // True when y is strictly larger than x as a float, -0 below +0.
    function automatic bit greater(input logic [31:0] x, input logic [31:0] y);
        if (x[31] != y[31]) return x[31];
        if (!x[31]) return y[30:0] > x[30:0];
        return y[30:0] < x[30:0];
    endfunction

    function automatic logic [31:0] max4(input logic [31:0] p0, input logic [31:0] p1,
                                         input logic [31:0] p2, input logic [31:0] p3);
        logic [31:0] m;
        m = p0;
        if (greater(m, p1)) m = p1;
        if (greater(m, p2)) m = p2;
        if (greater(m, p3)) m = p3;
        return m;
    endfunction

    task automatic pool_a();
        for (int wr = 0; wr < 2; wr++)
            for (int wc = 0; wc < 2; wc++)
                pa[wr*2+wc] = max4(fa[(2*wr)*NA+2*wc], fa[(2*wr)*NA+2*wc+1],
                                   fa[(2*wr+1)*NA+2*wc], fa[(2*wr+1)*NA+2*wc+1]);
    endtask

    task automatic fill_ramp();
        logic [31:0] ramp [16];
        ramp = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000,
                 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                 32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        for (int i = 0; i < 16; i++) fa[i] = ramp[i];
        pa[0] = 32'h40c00000;
        pa[1] = 32'h41000000;
        pa[2] = 32'h41600000;
        pa[3] = 32'h41800000;
    endtask

    // Streams the first n pixels of fa with random idle gaps, checking every cycle.
    task automatic stream_a(input string name, input int n, input int max_gap);
        int          k   = 0;
        int          gap = 0;
        logic        ev  = 1'b0;
        logic        efd = 1'b0;
        logic [31:0] ed  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            total++;
            if (a_vout !== ev) begin
                bad++;
                $display("FAIL %s valid_out cyc=%0d got=%b want=%b", name, cyc, a_vout, ev);
            end
            total++;
            if (a_dout !== (ev ? ed : a_last)) begin
                bad++;
                $display("FAIL %s data_out cyc=%0d got=%h want=%h", name, cyc, a_dout,
                         ev ? ed : a_last);
            end
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
            total++;
            if (a_fd !== efd) begin
                bad++;
                $display("FAIL %s frame_done cyc=%0d got=%b want=%b", name, cyc, a_fd, efd);
            end
`endif
            if (ev) a_last = ed;
            if (k == n) begin
                a_vin = 1'b0;
                break;
            end
            if (gap > 0) begin
                a_vin = 1'b0;
                a_din = $urandom;
                ev    = 1'b0;
                efd   = 1'b0;
                gap--;
            end else begin
                a_vin = 1'b1;
                a_din = fa[k];
                ev    = ((k / NA) % 2 == 1) && ((k % NA) % 2 == 1);
                efd   = (k == 15);
                ed    = pa[(k / 8) * 2 + (k % NA) / 2];
                k++;
                gap   = int'($urandom_range(0, max_gap));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;
        a_vin = 1'b1; b_vin = 1'b1;
        a_din = $urandom; b_din = $urandom;
        @(negedge clk);
        total++;
        if (a_vout !== 1'b0 || a_dout !== 32'h0) begin
            bad++;
            $display("FAIL reset_a got v=%b d=%h want v=0 d=0", a_vout, a_dout);
        end
        total++;
        if (b_vout !== 1'b0 || b_dout !== 32'h0) begin
            bad++;
            $display("FAIL reset_b got v=%b d=%h want v=0 d=0", b_vout, b_dout);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        a_vin = 1'b0; b_vin = 1'b0;
        a_last = '0;
    endtask

    task automatic test_ramp();
        fill_ramp();
        stream_a("ramp", 16, 0);
    endtask

    task automatic test_negative();
        for (int i = 0; i < 16; i++) fa[i] = {1'b1, 31'($urandom)};
        fa[0] = 32'hbf800000; fa[1] = 32'hc0000000;
        fa[4] = 32'hc0400000; fa[5] = 32'hc0800000;
        fa[2] = 32'h80000000; fa[3] = 32'h00000000;
        fa[6] = 32'hc0a00000; fa[7] = 32'hc0c00000;
        pool_a();
        pa[0] = 32'hbf800000;
        pa[1] = 32'h00000000;
        stream_a("negative", 16, 0);
    endtask

    task automatic test_gaps();
        fill_ramp();
        stream_a("gaps", 16, 5);
        for (int i = 0; i < 16; i++) fa[i] = $urandom;
        pool_a();
        stream_a("gaps_rand", 16, 5);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) fa[i] = $urandom;
        pool_a();
        stream_a("abort_part", 9, 2);
        @(negedge clk);
        a_rst = 1'b1;
        a_vin = 1'b1;
        a_din = $urandom;
        @(negedge clk);
        total++;
        if (a_vout !== 1'b0 || a_dout !== 32'h0) begin
            bad++;
            $display("FAIL abort_reset got v=%b d=%h want v=0 d=0", a_vout, a_dout);
        end
        a_rst  = 1'b0;
        a_vin  = 1'b0;
        a_last = '0;
        fill_ramp();
        stream_a("abort_ramp", 16, 0);
    endtask

    task automatic test_back_to_back();
        int          pulses = 0;
        int          fdn    = 0;
        logic        ev     = 1'b0;
        logic        efd    = 1'b0;
        logic [31:0] ed     = '0;
        for (int i = 0; i < 2*PB; i++) fb[i] = $urandom;
        for (int k = 0; k <= 2*PB; k++) begin
            @(negedge clk);
            total++;
            if (b_vout !== ev) begin
                bad++;
                $display("FAIL b2b valid_out k=%0d got=%b want=%b", k, b_vout, ev);
            end
            if (b_vout === 1'b1) pulses++;
            if (ev) begin
                total++;
                if (b_dout !== ed) begin
                    bad++;
                    $display("FAIL b2b data_out k=%0d got=%h want=%h", k, b_dout, ed);
                end
            end
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
            total++;
            if (b_fd !== efd) begin
                bad++;
                $display("FAIL b2b frame_done k=%0d got=%b want=%b", k, b_fd, efd);
            end
            if (b_fd === 1'b1) fdn++;
`endif
            if (k == 2*PB) begin
                b_vin = 1'b0;
                break;
            end
            b_vin = 1'b1;
            b_din = fb[k];
            begin
                int base, p, r, c;
                base = (k / PB) * PB;
                p    = k % PB;
                r    = p / NB;
                c    = p % NB;
                ev   = (r % 2 == 1) && (c % 2 == 1);
                efd  = (p == PB - 1);
                if (ev)
                    ed = max4(fb[base+(r-1)*NB+c-1], fb[base+(r-1)*NB+c],
                              fb[base+r*NB+c-1], fb[base+r*NB+c]);
            end
        end
        total++;
        if (pulses != 2 * (NB/2) * (NB/2)) begin
            bad++;
            $display("FAIL b2b pulse_count got=%0d want=%0d", pulses, 2 * (NB/2) * (NB/2));
        end
`ifdef LAYER_2_MAXPOOL_FRAME_DONE_EN
        total++;
        if (fdn != 2) begin
            bad++;
            $display("FAIL b2b frame_done_count got=%0d want=2", fdn);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_gaps();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
